ahb_des_slave_regs: RTL and testbench

//  AHB-Lite slave register file that fronts the Triple DES core with a pipelined address/data-phase interface.

---
 rtl/ahb_des_slave_regs.sv | 232 +++++++++++++++++++++++
 tb/tb_ahb_des_slave_regs.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_des_slave_regs.sv
// AHB-Lite register front end for the Triple DES core: control/status, data and key
// registers, a start pulse to the core, stalled result reads and two-cycle error responses.
module ahb_des_slave_regs #(
    parameter logic [31:0] BASE_ADDR  = 32'hAAAA_AA00,
    parameter int          NUM_KEYS   = 3,
    parameter bit          BUSY_STALL = 1'b1,
    parameter int          MAX_WAIT   = 64
) (
    input  logic                     HCLK,
    input  logic                     HRESET,
    input  logic                     HSEL,
    input  logic [31:0]              HADDR,
    input  logic                     HWRITE,
    input  logic [1:0]               HTRANS,
    input  logic [2:0]               HSIZE,
    input  logic                     HREADY,
    input  logic [63:0]              HWDATA,
    output logic                     HREADYOUT,
    output logic                     HRESP,
    output logic [63:0]              HRDATA,
    output logic                     enable,
    output logic                     encryption_type,
    output logic [63:0]              data,
    output logic [64*NUM_KEYS-1:0]   key,
    input  logic [63:0]              output_data,
    input  logic                     core_done,
    output logic [1:0]               fsm_state
);

    // Bus handshake: an address phase is taken when HSEL & HREADY & HTRANS[1] and the slave
    // is in a state that ends a data phase (ACC without an error, or ERR2); a data phase
    // completes on the rising edge where HREADYOUT=1.
    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_STALL = 2'd1,
        ST_ERR1  = 2'd2,
        ST_ERR2  = 2'd3
    } state_t;

    localparam logic [4:0] SLOT_CTRL   = 5'd0;
    localparam logic [4:0] SLOT_STATUS = 5'd1;
    localparam logic [4:0] SLOT_DIN    = 5'd2;
    localparam logic [4:0] SLOT_DOUT   = 5'd3;
    localparam logic [4:0] SLOT_KEY0   = 5'd4;
    localparam logic [4:0] SLOT_END    = 5'(4 + NUM_KEYS);
    localparam logic [7:0] WAIT_LAST   = 8'(MAX_WAIT - 1);

    state_t       state;
    state_t       state_nxt;

    logic         dp_valid;
    logic         dp_write;
    logic [4:0]   dp_slot;
    logic [7:0]   wait_cnt;

    logic         mode_r;
    logic         busy_r;
    logic         done_r;
    logic         enable_r;
    logic [63:0]  data_in_r;
    logic [63:0]  data_out_r;
    logic [63:0]  key_r [NUM_KEYS];

    logic         addr_phase;
    logic         accepting;
    logic         capture;
    logic         dp_wr_acc;
    logic         ctrl_wr;
    logic         ctrl_err;
    logic         start_fire;
    logic         wr_commit;
    logic         dout_read_done;
    logic         done_accept;
    logic         busy_at_cap;
    logic [4:0]   cap_slot;
    logic         cap_illegal;
    logic         cap_stall;
    logic [63:0]  rd_mux;
    logic         unused_htrans0;

    assign unused_htrans0 = HTRANS[0];

    assign addr_phase  = HSEL & HREADY & HTRANS[1];
    assign dp_wr_acc   = (state == ST_ACC) & dp_valid & dp_write;
    assign ctrl_wr     = dp_wr_acc & (dp_slot == SLOT_CTRL);
    // START can only be seen in HWDATA, so a START-while-busy write is rejected in its data phase.
    assign ctrl_err    = ctrl_wr & HWDATA[0] & busy_r;
    assign start_fire  = ctrl_wr & HWDATA[0] & ~busy_r;
    assign wr_commit   = dp_wr_acc & ~ctrl_err;
    assign dout_read_done = (state == ST_ACC) & dp_valid & ~dp_write & (dp_slot == SLOT_DOUT);
    assign done_accept = core_done & busy_r;

    assign accepting   = ((state == ST_ACC) & ~ctrl_err) | (state == ST_ERR2);
    assign capture     = addr_phase & accepting;

    // Busy as it will be once the current edge has been taken into account.
    assign busy_at_cap = start_fire | (busy_r & ~core_done);
    assign cap_slot    = HADDR[7:3];

    assign cap_illegal = (HADDR[31:8] != BASE_ADDR[31:8])
                       | (HADDR[2:0] != 3'd0)
                       | (HSIZE != 3'b011)
                       | (cap_slot >= SLOT_END)
                       | (HWRITE & ((cap_slot == SLOT_STATUS) | (cap_slot == SLOT_DOUT)))
                       | (HWRITE & busy_at_cap & ((cap_slot == SLOT_DIN) | (cap_slot >= SLOT_KEY0)));

    assign cap_stall   = (BUSY_STALL != 1'b0) & ~HWRITE & (cap_slot == SLOT_DOUT) & busy_at_cap;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_ACC, ST_ERR2: begin
                if (ctrl_err) begin
                    state_nxt = ST_ERR2;
                end else if (capture && cap_illegal) begin
                    state_nxt = ST_ERR1;
                end else if (capture && cap_stall) begin
                    state_nxt = ST_STALL;
                end else begin
                    state_nxt = ST_ACC;
                end
            end
            ST_STALL: begin
                if (done_accept) begin
                    state_nxt = ST_ACC;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt = ST_ERR1;
                end else begin
                    state_nxt = ST_STALL;
                end
            end
            ST_ERR1: state_nxt = ST_ERR2;
            default: state_nxt = ST_ACC;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state    <= ST_ACC;
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_slot  <= 5'd0;
            wait_cnt <= 8'd0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                dp_valid <= ~cap_illegal;
                dp_write <= HWRITE;
                dp_slot  <= cap_slot;
            end else if ((state != ST_STALL) || (state_nxt == ST_ERR1)) begin
                dp_valid <= 1'b0;
            end
            if (state == ST_STALL) begin
                wait_cnt <= wait_cnt + 8'd1;
            end else begin
                wait_cnt <= 8'd0;
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            mode_r     <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            enable_r   <= 1'b0;
            data_in_r  <= 64'd0;
            data_out_r <= 64'd0;
            for (int k = 0; k < NUM_KEYS; k++) begin
                key_r[k] <= 64'd0;
            end
        end else begin
            enable_r <= start_fire;
            if (wr_commit && (dp_slot == SLOT_CTRL)) begin
                mode_r <= HWDATA[1];
            end
            if (wr_commit && (dp_slot == SLOT_DIN)) begin
                data_in_r <= HWDATA;
            end
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (wr_commit && (dp_slot == 5'(4 + k))) begin
                    key_r[k] <= HWDATA;
                end
            end
            if (start_fire) begin
                busy_r <= 1'b1;
            end else if (done_accept) begin
                busy_r <= 1'b0;
            end
            if (done_accept) begin
                data_out_r <= output_data;
            end
            // A fresh result outranks a read that clears DONE on the same edge.
            if (done_accept) begin
                done_r <= 1'b1;
            end else if (start_fire || dout_read_done) begin
                done_r <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_mux = 64'd0;
        case (dp_slot)
            SLOT_CTRL:   rd_mux = {62'd0, mode_r, 1'b0};
            SLOT_STATUS: rd_mux = {62'd0, done_r, busy_r};
            SLOT_DIN:    rd_mux = data_in_r;
            SLOT_DOUT:   rd_mux = data_out_r;
            default: begin
                for (int k = 0; k < NUM_KEYS; k++) begin
                    if (dp_slot == 5'(4 + k)) begin
                        rd_mux = key_r[k];
                    end
                end
            end
        endcase
    end

    assign HREADYOUT = ~((state == ST_STALL) | (state == ST_ERR1) | ctrl_err);
    assign HRESP     = (state == ST_ERR1) | (state == ST_ERR2) | ctrl_err;
    assign HRDATA    = ((state == ST_ACC) && dp_valid && !dp_write) ? rd_mux : 64'd0;

    assign enable          = enable_r;
    assign encryption_type = mode_r;
    assign data            = data_in_r;
    assign fsm_state       = state;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key_out
        assign key[64*g +: 64] = key_r[g];
    end

endmodule

// File: tb/tb_ahb_des_slave_regs.sv
// Bench for ahb_des_slave_regs: directed scenarios plus random register traffic checked
// against a transaction-level model of the register map.
module tb_ahb_des_slave_regs;

    localparam logic [31:0] BASE = 32'hAAAA_AA00;
    localparam int          NK   = 3;
    localparam int          MW   = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              hsel = 1'b0;
    logic [31:0]       haddr = 32'd0;
    logic              hwrite = 1'b0;
    logic [1:0]        htrans = 2'b00;
    logic [2:0]        hsize = 3'b011;
    logic              hready;
    logic [63:0]       hwdata = 64'd0;
    logic              hreadyout;
    logic              hresp;
    logic [63:0]       hrdata;
    logic              enable;
    logic              encryption_type;
    logic [63:0]       data;
    logic [64*NK-1:0]  key;
    logic [63:0]       output_data = 64'd0;
    logic              core_done = 1'b0;
    logic [1:0]        dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model of the programmer-visible state
    logic        m_mode, m_busy, m_done;
    logic [63:0] m_din, m_dout;
    logic [63:0] m_key [NK];
    logic [63:0] exp_q [$];

    assign hready = hreadyout;

    ahb_des_slave_regs #(.BASE_ADDR(BASE), .NUM_KEYS(NK), .BUSY_STALL(1'b1), .MAX_WAIT(MW)) dut (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel), .HADDR(haddr), .HWRITE(hwrite),
        .HTRANS(htrans), .HSIZE(hsize), .HREADY(hready), .HWDATA(hwdata),
        .HREADYOUT(hreadyout), .HRESP(hresp), .HRDATA(hrdata),
        .enable(enable), .encryption_type(encryption_type), .data(data), .key(key),
        .output_data(output_data), .core_done(core_done), .fsm_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 1'b0; m_busy = 1'b0; m_done = 1'b0;
        m_din = 64'd0; m_dout = 64'd0;
        for (int k = 0; k < NK; k++) m_key[k] = 64'd0;
        exp_q.delete();
    endtask

    task automatic model_done(input logic [63:0] od);
        if (m_busy) begin
            m_dout = od;
            m_busy = 1'b0;
            m_done = 1'b1;
        end
    endtask

    task automatic model_xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                              input logic [63:0] wd, output logic e_resp, output int e_waits,
                              output logic e_en);
        int          slot;
        bit          bad;
        logic [63:0] rd;
        slot = int'(addr[7:0]) / 8;
        bad  = (addr[31:8] != BASE[31:8]) || (addr[2:0] != 3'd0) || (size != 3'd3) || (slot >= 4 + NK);
        if (wr && (slot == 1 || slot == 3)) bad = 1'b1;
        if (wr && m_busy && (slot == 2 || slot >= 4 || (slot == 0 && wd[0]))) bad = 1'b1;
        rd = 64'd0;
        e_en = 1'b0;
        if (bad) begin
            e_resp = 1'b1; e_waits = 1;
        end else if (!wr && slot == 3 && m_busy) begin
            e_resp = 1'b1; e_waits = MW + 1;
        end else begin
            e_resp = 1'b0; e_waits = 0;
            if (wr) begin
                if (slot == 0) begin
                    m_mode = wd[1];
                    if (wd[0]) begin
                        m_busy = 1'b1; m_done = 1'b0; e_en = 1'b1;
                    end
                end else if (slot == 2) m_din = wd;
                else m_key[slot-4] = wd;
            end else begin
                case (slot)
                    0: rd = {62'd0, m_mode, 1'b0};
                    1: rd = {62'd0, m_done, m_busy};
                    2: rd = m_din;
                    3: begin rd = m_dout; m_done = 1'b0; end
                    default: rd = m_key[slot-4];
                endcase
            end
        end
        exp_q.push_back(rd);
    endtask

    // One complete transfer: address phase, then data phase until HREADYOUT. Returns at posedge+1.
    task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                           input logic [63:0] wd, output logic [63:0] rd, output logic resp,
                           output int waits);
        hsel = 1'b1; htrans = 2'b10; hwrite = wr; haddr = addr; hsize = size;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = wd;
        waits = 0; rd = 64'd0; resp = 1'b0;
        forever begin
            @(negedge clk);
            if (hreadyout) begin
                rd = hrdata; resp = hresp;
                break;
            end
            waits++;
            if (waits > 300) begin
                check_val("xfer_timeout", 64'(waits), 64'd300);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, "_data"}, data, m_din);
        check_val({tag, "_mode"}, 64'(encryption_type), 64'(m_mode));
        for (int k = 0; k < NK; k++) check_val({tag, "_key"}, key[64*k +: 64], m_key[k]);
    endtask

    task automatic run_xfer(input string tag, input logic wr, input logic [31:0] addr,
                            input logic [2:0] size, input logic [63:0] wd);
        logic        e_resp, e_en, resp;
        int          e_waits, waits;
        logic [63:0] rd, e_rd;
        model_xfer(wr, addr, size, wd, e_resp, e_waits, e_en);
        do_xfer(wr, addr, size, wd, rd, resp, waits);
        e_rd = exp_q.pop_front();
        check_val({tag, "_rdata"}, rd, e_rd);
        check_val({tag, "_resp"}, 64'(resp), 64'(e_resp));
        check_val({tag, "_waits"}, 64'(waits), 64'(e_waits));
        check_val({tag, "_enable"}, 64'(enable), 64'(e_en));
        check_outputs(tag);
    endtask

    task automatic pulse_done(input logic [63:0] od);
        core_done = 1'b1; output_data = od;
        @(posedge clk); #1;
        core_done = 1'b0;
        model_done(od);
    endtask

    initial begin
        logic [63:0] v, rd;
        logic        resp;
        int          waits;

        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        check_val("rst_hreadyout", 64'(hreadyout), 64'd1);
        check_val("rst_hresp", 64'(hresp), 64'd0);
        check_val("rst_hrdata", hrdata, 64'd0);
        check_val("rst_enable", 64'(enable), 64'd0);
        check_val("rst_state", 64'(dbg_state), 64'd0);
        check_outputs("rst");
        @(posedge clk); #1;

        // Load keys and data, then start an encryption
        run_xfer("wr_key0", 1'b1, BASE + 32'h20, 3'd3, 64'h1334_5779_9BBC_DFF1);
        run_xfer("wr_key1", 1'b1, BASE + 32'h28, 3'd3, 64'h0E32_9232_EA6D_0D73);
        run_xfer("wr_key2", 1'b1, BASE + 32'h30, 3'd3, 64'hA1B2_C3D4_E5F6_0718);
        run_xfer("wr_din", 1'b1, BASE + 32'h10, 3'd3, 64'h0123_4567_89AB_CDEF);
        run_xfer("start", 1'b1, BASE + 32'h00, 3'd3, 64'd3);
        @(posedge clk); #1;
        check_val("enable_one_cycle", 64'(enable), 64'd0);
        check_val("encrypt_mode", 64'(encryption_type), 64'd1);
        run_xfer("status_busy", 1'b0, BASE + 32'h08, 3'd3, 64'd0);

        // Result capture and read
        pulse_done(64'h85E8_1354_0F0A_B405);
        run_xfer("status_done", 1'b0, BASE + 32'h08, 3'd3, 64'd0);
        run_xfer("rd_dout", 1'b0, BASE + 32'h18, 3'd3, 64'd0);
        run_xfer("status_clear", 1'b0, BASE + 32'h08, 3'd3, 64'd0);

        // DATA_OUT read while busy, result arrives during the stall
        run_xfer("start2", 1'b1, BASE + 32'h00, 3'd3, 64'd3);
        fork
            do_xfer(1'b0, BASE + 32'h18, 3'd3, 64'd0, rd, resp, waits);
            begin
                @(posedge clk);
                repeat (9) @(posedge clk);
                #1; core_done = 1'b1; output_data = 64'hCAFE_F00D_1234_5678;
                @(posedge clk); #1; core_done = 1'b0;
            end
        join
        check_val("stall_waits", 64'(waits), 64'd10);
        check_val("stall_resp", 64'(resp), 64'd0);
        check_val("stall_rdata", rd, 64'hCAFE_F00D_1234_5678);
        m_busy = 1'b0; m_done = 1'b0; m_dout = 64'hCAFE_F00D_1234_5678;
        run_xfer("status_after_stall", 1'b0, BASE + 32'h08, 3'd3, 64'd0);

        // Stall with no result: aborts after MAX_WAIT cycles
        run_xfer("start3", 1'b1, BASE + 32'h00, 3'd3, 64'd1);
        run_xfer("stall_abort", 1'b0, BASE + 32'h18, 3'd3, 64'd0);

        // Illegal accesses while busy
        run_xfer("ill_off38", 1'b0, BASE + 32'h38, 3'd3, 64'd0);
        run_xfer("ill_wr_status", 1'b1, BASE + 32'h08, 3'd3, 64'hFFFF);
        run_xfer("ill_size2", 1'b0, BASE + 32'h10, 3'd2, 64'd0);
        run_xfer("ill_key1_busy", 1'b1, BASE + 32'h28, 3'd3, 64'hDEAD_BEEF_DEAD_BEEF);
        run_xfer("ill_din_busy", 1'b1, BASE + 32'h10, 3'd3, 64'h5555);
        run_xfer("ill_start_busy", 1'b1, BASE + 32'h00, 3'd3, 64'd3);
        run_xfer("ill_base", 1'b0, 32'hAAAA_AB10, 3'd3, 64'd0);
        run_xfer("ill_misalign", 1'b0, BASE + 32'h14, 3'd3, 64'd0);
        run_xfer("ctrl_mode_busy", 1'b1, BASE + 32'h00, 3'd3, 64'd2);
        pulse_done(64'h0BAD_CAFE_0BAD_CAFE);
        run_xfer("rd_dout2", 1'b0, BASE + 32'h18, 3'd3, 64'd0);

        // Back-to-back write then read of DATA_IN
        v = {$urandom, $urandom};
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = BASE + 32'h10; hsize = 3'd3;
        @(posedge clk); #1;
        hwrite = 1'b0; hwdata = v;
        @(negedge clk);
        check_val("b2b_wr_ready", 64'(hreadyout), 64'd1);
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00;
        @(negedge clk);
        check_val("b2b_rd_ready", 64'(hreadyout), 64'd1);
        check_val("b2b_rd_data", hrdata, v);
        @(posedge clk); #1;
        m_din = v;
        check_outputs("b2b");

        // Reset in the middle of a stalled read
        run_xfer("start4", 1'b1, BASE + 32'h00, 3'd3, 64'd3);
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = BASE + 32'h18; hsize = 3'd3;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00;
        repeat (3) @(negedge clk);
        check_val("pre_rst_stalled", 64'(hreadyout), 64'd0);
        rst = 1'b1; #1;
        model_reset();
        check_val("mid_rst_hreadyout", 64'(hreadyout), 64'd1);
        check_val("mid_rst_hresp", 64'(hresp), 64'd0);
        check_val("mid_rst_hrdata", hrdata, 64'd0);
        check_val("mid_rst_enable", 64'(enable), 64'd0);
        check_outputs("mid_rst");
        @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check_val("post_rst_enable", 64'(enable), 64'd0);
        run_xfer("post_rst_status", 1'b0, BASE + 32'h08, 3'd3, 64'd0);
        run_xfer("post_rst_dout", 1'b0, BASE + 32'h18, 3'd3, 64'd0);

        // Random traffic against the model
        for (int i = 0; i < 200; i++) begin
            logic        wr;
            logic [31:0] addr;
            logic [2:0]  size;
            logic [63:0] wd;
            int          slot;
            if ($urandom_range(0, 3) == 0) begin
                pulse_done({$urandom, $urandom});
            end
            wr   = 1'($urandom_range(0, 1));
            slot = $urandom_range(0, 8);
            addr = BASE + 32'(slot * 8);
            if ($urandom_range(0, 9) == 0) addr = addr + 32'($urandom_range(1, 7));
            if ($urandom_range(0, 19) == 0) addr = addr ^ (32'h1 << $urandom_range(8, 31));
            size = 3'd3;
            if ($urandom_range(0, 9) == 0) size = 3'($urandom_range(0, 2));
            wd = {$urandom, $urandom};
            run_xfer("rand", wr, addr, size, wd);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
